// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg                                                       |
// | Shared opcodes, FSM state encoding and helpers for the hazard controller.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_detect                                                              |
// | Combinational load-use comparator between the EX load and the ID operands. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
    assign load_use  = ex_is_load & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                           |
// | Stall/flush/bubble controller for the 5-stage RV32I pipeline.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_is_load_i,
    input  logic        ex_redirect_i,
    input  logic        mem_req_i,
    input  logic        dmem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_bubble_o,
    output logic        pc_redirect_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_inc;
    logic        r_timeout;
    logic [31:0] r_stall_cnt;

    logic w_freeze;
    logic w_load_use;
    logic w_lu_stall;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_stall;
    logic w_id_ex_flush;
    logic w_ex_mem_stall;
    logic w_mem_wb_bubble;
    logic w_pc_redirect;

    assign w_freeze   = mem_req_i & ~dmem_ready_i;
    assign w_wait_inc = r_wait_cnt + 8'd1;

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .id_use_rs1 (id_use_rs1_i),
        .id_use_rs2 (id_use_rs2_i),
        .ex_rd      (ex_rd_i),
        .ex_is_load (ex_is_load_i),
        .load_use   (w_load_use)
    );

    // A load-use only costs a frozen slot when neither a freeze nor a redirect wins.
    assign w_lu_stall = ~w_freeze & ~ex_redirect_i & w_load_use;

    always_comb begin
        w_next_state    = r_state;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_pc_redirect   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_freeze) begin
                    w_next_state = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i | ~mem_req_i) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase

        if (w_freeze) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_stall   = 1'b1;
            w_ex_mem_stall  = 1'b1;
            w_mem_wb_bubble = 1'b1;
        end else if (ex_redirect_i) begin
            w_pc_redirect   = 1'b1;
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
        end else if (w_load_use) begin
            w_pc_stall      = 1'b1;
            w_if_id_stall   = 1'b1;
            w_id_ex_flush   = 1'b1;
        end
    end

    // Strobes are gated so the pipeline sees nothing while reset is held.
    assign pc_stall_o      = rst_n & w_pc_stall;
    assign if_id_stall_o   = rst_n & w_if_id_stall;
    assign if_id_flush_o   = rst_n & w_if_id_flush;
    assign id_ex_stall_o   = rst_n & w_id_ex_stall;
    assign id_ex_flush_o   = rst_n & w_id_ex_flush;
    assign ex_mem_stall_o  = rst_n & w_ex_mem_stall;
    assign mem_wb_bubble_o = rst_n & w_mem_wb_bubble;
    assign pc_redirect_o   = rst_n & w_pc_redirect;
    assign mem_timeout_o   = r_timeout;
    assign stall_cnt_o     = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_next_state;

            // Only frozen MEM_WAIT cycles count; the release cycle is not a wait.
            if (r_state == ST_RUN && w_freeze) begin
                r_wait_cnt <= 8'd0;
            end else if (r_state == ST_MEM_WAIT && w_freeze && r_wait_cnt != C_TIMEOUT) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == C_TIMEOUT) begin
                    r_timeout <= 1'b1;
                end
            end

            if (w_freeze | w_lu_stall) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                                        |
// | Directed and randomized checks against a rule-level reference model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        use1 = 1'b0, use2 = 1'b0, is_load = 1'b0, redirect = 1'b0;
    logic        mem_req = 1'b0, ready = 1'b1;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_bubble, pc_redirect, mem_timeout;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int          m_streak = 0;
    logic        m_timeout = 1'b0;
    longint      m_stall_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1_i        (id_rs1),
        .id_rs2_i        (id_rs2),
        .id_use_rs1_i    (use1),
        .id_use_rs2_i    (use2),
        .ex_rd_i         (ex_rd),
        .ex_is_load_i    (is_load),
        .ex_redirect_i   (redirect),
        .mem_req_i       (mem_req),
        .dmem_ready_i    (ready),
        .pc_stall_o      (pc_stall),
        .if_id_stall_o   (if_id_stall),
        .if_id_flush_o   (if_id_flush),
        .id_ex_stall_o   (id_ex_stall),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_stall_o  (ex_mem_stall),
        .mem_wb_bubble_o (mem_wb_bubble),
        .pc_redirect_o   (pc_redirect),
        .mem_timeout_o   (mem_timeout),
        .stall_cnt_o     (stall_cnt)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble, pc_redirect}
    localparam logic [7:0] S_NONE   = 8'b0000_0000;
    localparam logic [7:0] S_FREEZE = 8'b1101_0110;
    localparam logic [7:0] S_REDIR  = 8'b0010_1001;
    localparam logic [7:0] S_LU     = 8'b1100_1000;

    function automatic logic [7:0] observed();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_stall, mem_wb_bubble, pc_redirect};
    endfunction

    function automatic logic model_lu();
        return is_load && ex_rd != 0 && ((use1 && id_rs1 == ex_rd) || (use2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [7:0] model_strobes();
        if (mem_req && !ready) return S_FREEZE;
        if (redirect)          return S_REDIR;
        if (model_lu())        return S_LU;
        return S_NONE;
    endfunction

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; use1 = 0; use2 = 0;
        is_load = 0; redirect = 0; mem_req = 0; ready = 1;
    endtask

    task automatic model_reset();
        m_streak = 0; m_timeout = 1'b0; m_stall_cnt = 0;
    endtask

    // Advance one clock, applying the spec rules to the model, and return at the negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (mem_req && !ready) begin
                m_streak++;
                if (m_streak > int'(TO)) m_timeout = 1'b1;
            end else begin
                m_streak = 0;
            end
            if ((mem_req && !ready) || (!redirect && model_lu()))
                if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        mem_req = 1; ready = 0; redirect = 1;
        is_load = 1; ex_rd = 3; id_rs1 = 3; use1 = 1;
        #1;
        n_checks++;
        if ({observed(), mem_timeout, stall_cnt} !== 41'd0)
            $display("FAIL reset_outputs: got strobes=%b to=%b cnt=%0d, want all 0", observed(), mem_timeout, stall_cnt);
        else n_pass++;
        @(negedge clk);
        do_reset();
        #1;
        n_checks++;
        if ({observed(), mem_timeout, stall_cnt} !== 41'd0)
            $display("FAIL reset_release: got strobes=%b to=%b cnt=%0d, want all 0", observed(), mem_timeout, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        is_load = 1; ex_rd = 1; id_rs1 = 1; id_rs2 = 2; use1 = 1; use2 = 1;
        #1;
        n_checks++;
        if (observed() !== S_LU) $display("FAIL load_use_strobes: got %b want %b", observed(), S_LU);
        else n_pass++;
        tick();
        is_load = 0; ex_rd = 3;
        #1;
        n_checks++;
        if (observed() !== S_NONE) $display("FAIL load_use_clear: got %b want %b", observed(), S_NONE);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 32'd1) $display("FAIL load_use_count: got %0d want 1", stall_cnt);
        else n_pass++;
        // rs2 match only
        is_load = 1; ex_rd = 7; id_rs1 = 5; id_rs2 = 7; use1 = 1; use2 = 1;
        #1;
        n_checks++;
        if (observed() !== S_LU) $display("FAIL load_use_rs2: got %b want %b", observed(), S_LU);
        else n_pass++;
        // Match on an operand the instruction does not read
        use2 = 0;
        #1;
        n_checks++;
        if (observed() !== S_NONE) $display("FAIL load_use_unused_rs2: got %b want %b", observed(), S_NONE);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; use1 = 1; use2 = 1;
        #1;
        n_checks++;
        if (observed() !== S_NONE) $display("FAIL load_x0: got %b want %b", observed(), S_NONE);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_cnt !== 32'd0) $display("FAIL load_x0_count: got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_redirect_priority();
        do_reset();
        is_load = 1; ex_rd = 4; id_rs1 = 4; use1 = 1; redirect = 1;
        #1;
        n_checks++;
        if (observed() !== S_REDIR) $display("FAIL redirect_over_lu: got %b want %b", observed(), S_REDIR);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_cnt !== 32'd0) $display("FAIL redirect_count: got %0d want 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        mem_req = 1; ready = 0;
        is_load = 1; ex_rd = 2; id_rs2 = 2; use2 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (observed() !== S_FREEZE) $display("FAIL freeze_cycle%0d: got %b want %b", i, observed(), S_FREEZE);
            else n_pass++;
            tick();
        end
        ready = 1; is_load = 0;
        #1;
        n_checks++;
        if (observed() !== S_NONE) $display("FAIL freeze_release: got %b want %b", observed(), S_NONE);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_cnt !== 32'd3) $display("FAIL freeze_count: got %0d want 3", stall_cnt);
        else n_pass++;
        // Back in RUN: a fresh single-cycle freeze followed by a withdrawn request.
        mem_req = 1; ready = 0;
        tick();
        mem_req = 0;
        #1;
        n_checks++;
        if (observed() !== S_NONE) $display("FAIL freeze_withdrawn: got %b want %b", observed(), S_NONE);
        else n_pass++;
        tick();
    endtask

    task automatic test_redirect_during_freeze();
        do_reset();
        redirect = 1; mem_req = 1; ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (pc_redirect !== 1'b0) $display("FAIL redirect_frozen%0d: got %b want 0", i, pc_redirect);
            else n_pass++;
            tick();
        end
        ready = 1;
        #1;
        n_checks++;
        if (observed() !== S_REDIR) $display("FAIL redirect_release: got %b want %b", observed(), S_REDIR);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; ready = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (mem_timeout !== m_timeout) $display("FAIL timeout_cycle%0d: got %b want %b", i, mem_timeout, m_timeout);
            else n_pass++;
        end
        n_checks++;
        if (mem_timeout !== 1'b1) $display("FAIL timeout_set: got %b want 1", mem_timeout);
        else n_pass++;
        ready = 1;
        tick();
        tick();
        n_checks++;
        if (mem_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
        else n_pass++;
        // Reset in the middle of a wait clears everything at once.
        ready = 0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({observed(), mem_timeout, stall_cnt} !== 41'd0)
            $display("FAIL reset_mid_wait: got strobes=%b to=%b cnt=%0d, want all 0", observed(), mem_timeout, stall_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_inputs();
        #1;
        n_checks++;
        if (observed() !== S_NONE) $display("FAIL after_mid_reset: got %b want %b", observed(), S_NONE);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            id_rs1   = 5'($urandom_range(0, 3));
            id_rs2   = 5'($urandom_range(0, 3));
            ex_rd    = 5'($urandom_range(0, 3));
            use1     = 1'($urandom_range(0, 1));
            use2     = 1'($urandom_range(0, 1));
            is_load  = ($urandom_range(0, 99) < 50);
            redirect = ($urandom_range(0, 99) < 15);
            mem_req  = ($urandom_range(0, 99) < 40);
            ready    = ($urandom_range(0, 99) < 45);
            #1;
            n_checks++;
            if (observed() !== model_strobes())
                $display("FAIL rand_strobes[%0d]: got %b want %b", i, observed(), model_strobes());
            else n_pass++;
            tick();
            n_checks++;
            if (stall_cnt !== 32'(m_stall_cnt) || mem_timeout !== m_timeout)
                $display("FAIL rand_counters[%0d]: got cnt=%0d to=%b want cnt=%0d to=%b",
                         i, stall_cnt, mem_timeout, m_stall_cnt, m_timeout);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_redirect_priority();
        test_freeze();
        test_redirect_during_freeze();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
